// File: rtl/tmds_channel_decoder.sv
// -----------------------------------------------------------------------------
// tmds_channel_decoder
//   Decodes one TMDS channel (10b -> 8b data or 2b control) and runs a word
//   alignment FSM that requests bit slips from the deserializer until control
//   tokens show up, then watches for loss of alignment.
//
// Ports
//   clk        in   TMDS pixel clock
//   rst_n      in   synchronous active-low reset
//   din[9:0]   in   parallel word, din[0] first on the wire
//   din_valid  in   din carries a new word this cycle
//   data[7:0]  out  decoded pixel byte (held on control tokens / idle cycles)
//   ctrl[1:0]  out  decoded {C1,C0} (held on data words / idle cycles)
//   de         out  1 = data valid video, 0 = ctrl valid
//   valid      out  din_valid delayed by one cycle
//   bitslip    out  one-cycle request to shift word alignment by one bit
//   aligned    out  word alignment locked
// -----------------------------------------------------------------------------
module tmds_channel_decoder #(
  parameter int LOCK_TOKENS   = 16,
  parameter int SEARCH_WORDS  = 1024,
  parameter int SLIP_WAIT     = 8,
  parameter int TIMEOUT_WORDS = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] din,
  input  logic       din_valid,
  output logic [7:0] data,
  output logic [1:0] ctrl,
  output logic       de,
  output logic       valid,
  output logic       bitslip,
  output logic       aligned
);

  // One word counter is shared by SEARCH, SLIP and LOCKED (only one of them
  // is ever live), so it is sized for the largest of the three limits.
  localparam int WMAX01 = (SEARCH_WORDS > SLIP_WAIT) ? SEARCH_WORDS : SLIP_WAIT;
  localparam int WMAX   = (WMAX01 > TIMEOUT_WORDS) ? WMAX01 : TIMEOUT_WORDS;
  localparam int TW     = $clog2(WMAX + 1);
  localparam int KW     = $clog2(LOCK_TOKENS + 1);

  localparam logic [TW-1:0] SEARCH_LIM  = TW'(SEARCH_WORDS);
  localparam logic [TW-1:0] SLIP_LIM    = TW'(SLIP_WAIT);
  localparam logic [TW-1:0] TIMEOUT_LIM = TW'(TIMEOUT_WORDS);
  localparam logic [KW-1:0] LOCK_LIM    = KW'(LOCK_TOKENS);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_SLIP    = 2'd1,
    ST_LOCKING = 2'd2,
    ST_LOCKED  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] word_cnt_q, word_cnt_d;
  logic [KW-1:0] tok_cnt_q, tok_cnt_d;

  logic [7:0] data_q, data_d;
  logic [1:0] ctrl_q, ctrl_d;
  logic       de_q, de_d;
  logic       valid_q, valid_d;
  logic       bitslip_q, bitslip_d;
  logic       aligned_q, aligned_d;

  // ---------------------------------------------------------------------------
  // Word decode: token lookup and TMDS data recovery
  // ---------------------------------------------------------------------------
  logic       is_tok;
  logic [1:0] tok_ctrl;
  logic [7:0] q;
  logic [7:0] dec;

  always_comb begin
    is_tok   = 1'b1;
    tok_ctrl = 2'b00;
    case (din)
      10'b1101010100: tok_ctrl = 2'b00;
      10'b0010101011: tok_ctrl = 2'b01;
      10'b0101010100: tok_ctrl = 2'b10;
      10'b1010101011: tok_ctrl = 2'b11;
      default:        is_tok   = 1'b0;
    endcase

    // din[9] marks an inverted payload; din[8] selects XOR vs XNOR chaining.
    q      = din[9] ? ~din[7:0] : din[7:0];
    dec    = '0;
    dec[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = din[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
  end

  // ---------------------------------------------------------------------------
  // Alignment FSM next-state and output computation
  // ---------------------------------------------------------------------------
  logic [TW-1:0] word_inc;
  logic [KW-1:0] tok_inc;

  assign word_inc = word_cnt_q + TW'(1);
  assign tok_inc  = tok_cnt_q + KW'(1);

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    tok_cnt_d  = tok_cnt_q;

    if (din_valid) begin
      case (state_q)
        ST_SEARCH: begin
          if (is_tok) begin
            state_d    = (LOCK_TOKENS <= 1) ? ST_LOCKED : ST_LOCKING;
            tok_cnt_d  = KW'(1);
            word_cnt_d = '0;
          end else if (word_inc >= SEARCH_LIM) begin
            state_d    = ST_SLIP;
            word_cnt_d = '0;
          end else begin
            word_cnt_d = word_inc;
          end
        end
        ST_SLIP: begin
          // Words arriving while the deserializer realigns are not trusted.
          if (word_inc >= SLIP_LIM) begin
            state_d    = ST_SEARCH;
            word_cnt_d = '0;
            tok_cnt_d  = '0;
          end else begin
            word_cnt_d = word_inc;
          end
        end
        ST_LOCKING: begin
          if (!is_tok) begin
            state_d    = ST_SEARCH;
            tok_cnt_d  = '0;
            word_cnt_d = '0;
          end else if (tok_inc >= LOCK_LIM) begin
            state_d    = ST_LOCKED;
            tok_cnt_d  = '0;
            word_cnt_d = '0;
          end else begin
            tok_cnt_d  = tok_inc;
          end
        end
        ST_LOCKED: begin
          if (is_tok) begin
            word_cnt_d = '0;
          end else if (word_inc >= TIMEOUT_LIM) begin
            state_d    = ST_SEARCH;
            word_cnt_d = '0;
          end else begin
            word_cnt_d = word_inc;
          end
        end
        default: begin
          state_d    = ST_SEARCH;
          word_cnt_d = '0;
          tok_cnt_d  = '0;
        end
      endcase
    end

    valid_d = din_valid;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    de_d    = de_q;
    if (din_valid) begin
      if (is_tok) begin
        ctrl_d = tok_ctrl;
        de_d   = 1'b0;
      end else begin
        data_d = dec;
        de_d   = 1'b1;
      end
    end

    // Only the SEARCH->SLIP transition pulses; SLIP always consumes at least
    // one valid word before SEARCH can fire again, so pulses never abut.
    bitslip_d = (state_q == ST_SEARCH) && (state_d == ST_SLIP);
    aligned_d = (state_d == ST_LOCKED);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_SEARCH;
      word_cnt_q <= '0;
      tok_cnt_q  <= '0;
      data_q     <= '0;
      ctrl_q     <= '0;
      de_q       <= 1'b0;
      valid_q    <= 1'b0;
      bitslip_q  <= 1'b0;
      aligned_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      tok_cnt_q  <= tok_cnt_d;
      data_q     <= data_d;
      ctrl_q     <= ctrl_d;
      de_q       <= de_d;
      valid_q    <= valid_d;
      bitslip_q  <= bitslip_d;
      aligned_q  <= aligned_d;
    end
  end

  assign data    = data_q;
  assign ctrl    = ctrl_q;
  assign de      = de_q;
  assign valid   = valid_q;
  assign bitslip = bitslip_q;
  assign aligned = aligned_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// -----------------------------------------------------------------------------
// tb_tmds_channel_decoder
//   Stimulus is applied on the falling edge and a behavioural model predicts
//   the registered outputs of the next rising edge; predictions go into a
//   scoreboard queue which a monitor drains just after every rising edge.
// -----------------------------------------------------------------------------
module tb_tmds_channel_decoder;

  localparam int LOCK_TOKENS   = 16;
  localparam int SEARCH_WORDS  = 1024;
  localparam int SLIP_WAIT     = 8;
  localparam int TIMEOUT_WORDS = 4096;

  localparam int M_SEARCH  = 0;
  localparam int M_SLIP    = 1;
  localparam int M_LOCKING = 2;
  localparam int M_LOCKED  = 3;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] din;
  logic       din_valid;
  logic [7:0] data;
  logic [1:0] ctrl;
  logic       de, valid, bitslip, aligned;

  tmds_channel_decoder #(
    .LOCK_TOKENS(LOCK_TOKENS), .SEARCH_WORDS(SEARCH_WORDS),
    .SLIP_WAIT(SLIP_WAIT), .TIMEOUT_WORDS(TIMEOUT_WORDS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .data(data), .ctrl(ctrl), .de(de), .valid(valid),
    .bitslip(bitslip), .aligned(aligned)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid;
    logic       bitslip;
    logic       aligned;
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] data;
  } obs_t;

  obs_t sb[$];
  int   n_vec   = 0;
  int   n_fail  = 0;
  bit   started = 1'b0;
  int   wcount  = 0;
  int   slip_at[$];

  // Model state: operating mode plus plain run-length bookkeeping.
  int   m_mode = M_SEARCH;
  int   m_run  = 0;
  int   m_toks = 0;
  int   m_left = 0;
  obs_t m_out  = '0;

  function automatic bit tok_lookup(input logic [9:0] w, output logic [1:0] c);
    logic [9:0] toks [4];
    toks[0] = T00; toks[1] = T01; toks[2] = T10; toks[3] = T11;
    c = 2'b00;
    for (int k = 0; k < 4; k++) begin
      if (w == toks[k]) begin
        c = 2'(k);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic logic [9:0] rot(input logic [9:0] w, input int o);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = w[(i + o) % 10];
    return r;
  endfunction

  function automatic logic [9:0] rand_tok();
    logic [1:0] c;
    c = 2'($urandom_range(0, 3));
    case (c)
      2'd0:    return T00;
      2'd1:    return T01;
      2'd2:    return T10;
      default: return T11;
    endcase
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] w;
    logic [1:0] c;
    w = 10'($urandom);
    while (tok_lookup(w, c)) w = 10'($urandom);
    return w;
  endfunction

  task automatic model_step(input bit r, input bit dv, input logic [9:0] w);
    logic [1:0] c;
    logic [7:0] qq, d;
    bit         t;
    if (!r) begin
      m_out  = '0;
      m_mode = M_SEARCH;
      m_run  = 0;
      m_toks = 0;
      m_left = 0;
    end else if (!dv) begin
      m_out.valid   = 1'b0;
      m_out.bitslip = 1'b0;
    end else begin
      t = tok_lookup(w, c);
      m_out.valid   = 1'b1;
      m_out.bitslip = 1'b0;
      if (t) begin
        m_out.de   = 1'b0;
        m_out.ctrl = c;
      end else begin
        qq = w[9] ? ~w[7:0] : w[7:0];
        d  = qq ^ {qq[6:0], 1'b0};
        if (!w[8]) d = d ^ 8'hFE;
        m_out.de   = 1'b1;
        m_out.data = d;
      end
      case (m_mode)
        M_SLIP: begin
          m_left--;
          if (m_left <= 0) begin m_mode = M_SEARCH; m_run = 0; m_toks = 0; end
        end
        M_SEARCH: begin
          if (t) begin
            m_toks = 1;
            m_run  = 0;
            m_mode = (m_toks >= LOCK_TOKENS) ? M_LOCKED : M_LOCKING;
          end else begin
            m_run++;
            if (m_run >= SEARCH_WORDS) begin
              m_out.bitslip = 1'b1;
              m_mode = M_SLIP;
              m_left = SLIP_WAIT;
              m_run  = 0;
            end
          end
        end
        M_LOCKING: begin
          if (t) begin
            m_toks++;
            if (m_toks >= LOCK_TOKENS) begin m_mode = M_LOCKED; m_run = 0; end
          end else begin
            m_mode = M_SEARCH; m_toks = 0; m_run = 0;
          end
        end
        default: begin
          if (t) m_run = 0;
          else begin
            m_run++;
            if (m_run >= TIMEOUT_WORDS) begin m_mode = M_SEARCH; m_run = 0; end
          end
        end
      endcase
      m_out.aligned = (m_mode == M_LOCKED);
    end
    sb.push_back(m_out);
  endtask

  task automatic cyc(input bit r, input bit dv, input logic [9:0] w);
    @(negedge clk);
    rst_n     = r;
    din_valid = dv;
    din       = w;
    if (r && dv) wcount++;
    model_step(r, dv, w);
    started = 1'b1;
  endtask

  task automatic tokens(input int n);
    repeat (n) cyc(1'b1, 1'b1, rand_tok());
  endtask

  task automatic datas(input int n);
    repeat (n) cyc(1'b1, 1'b1, rand_data());
  endtask

  task automatic check(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Monitor: one prediction per clock once stimulus has started.
  initial begin
    obs_t got, e;
    forever begin
      @(posedge clk);
      #1;
      if (started) begin
        got = '{valid, bitslip, aligned, de, ctrl, data};
        if (bitslip) slip_at.push_back(wcount);
        n_vec++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard underflow at %0t", $time);
        end else begin
          e = sb.pop_front();
          if (got !== e) begin
            n_fail++;
            $display("FAIL scoreboard t=%0t: got v=%b bs=%b al=%b de=%b ctrl=%b data=%h, want v=%b bs=%b al=%b de=%b ctrl=%b data=%h",
                     $time, got.valid, got.bitslip, got.aligned, got.de, got.ctrl, got.data,
                     e.valid, e.bitslip, e.aligned, e.de, e.ctrl, e.data);
          end
        end
      end
    end
  end

  initial begin
    int off, base, guard;
    rst_n = 1'b0; din_valid = 1'b0; din = '0;

    // Reset, then plain ctrl-00 tokens to lock.
    cyc(1'b0, 1'b0, 10'd0);
    cyc(1'b0, 1'b1, T11);
    repeat (LOCK_TOKENS) cyc(1'b1, 1'b1, T00);
    cyc(1'b1, 1'b0, 10'd0);
    cyc(1'b1, 1'b0, 10'd0);

    // Directed data words, then random traffic with idle gaps while locked.
    cyc(1'b1, 1'b1, 10'b0100000000);
    cyc(1'b1, 1'b1, 10'b1011111111);
    cyc(1'b1, 1'b0, 10'b0000000000);
    cyc(1'b1, 1'b1, 10'b0111111111);
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) cyc(1'b1, 1'b1, rand_tok());
      else cyc(1'b1, ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 9) < 3) ? rand_tok() : rand_data());
    end

    // Timeout: full run of data words drops lock; one short of it does not.
    tokens(1);
    datas(TIMEOUT_WORDS);
    cyc(1'b1, 1'b1, rand_data());
    tokens(LOCK_TOKENS);
    datas(TIMEOUT_WORDS - 1);
    tokens(1);
    datas(20);

    // Reset while aligned; LOCKING broken by a data word needs a fresh run.
    cyc(1'b0, 1'b1, T00);
    tokens(10);
    datas(1);
    tokens(LOCK_TOKENS - 1);
    datas(1);
    tokens(LOCK_TOKENS);

    // Reset during a nearly expired search count: no slip afterwards.
    cyc(1'b0, 1'b1, T00);
    datas(SEARCH_WORDS - 24);
    cyc(1'b0, 1'b1, rand_data());
    datas(30);
    tokens(LOCK_TOKENS);

    // Reset in the middle of SLIP.
    cyc(1'b0, 1'b0, 10'd0);
    datas(SEARCH_WORDS);
    datas(3);
    cyc(1'b0, 1'b1, rand_data());
    datas(20);
    tokens(LOCK_TOKENS);

    // Stream misaligned by three bits; slips walk the offset back to zero.
    cyc(1'b0, 1'b0, 10'd0);
    @(posedge clk); #2;
    slip_at.delete();
    base  = wcount;
    off   = 3;
    guard = 0;
    while (!m_out.aligned && guard < 12000) begin
      cyc(1'b1, 1'b1, rot(T00, off));
      if (m_out.bitslip) off = (off + 9) % 10;
      guard++;
    end
    cyc(1'b1, 1'b1, T00);
    @(posedge clk); #2;
    check("rotation aligned", int'(aligned), 1);
    check("rotation slip count", slip_at.size(), 3);
    if (slip_at.size() == 3) begin
      check("first slip word", slip_at[0] - base, SEARCH_WORDS);
      check("second slip gap", slip_at[1] - slip_at[0], SEARCH_WORDS + SLIP_WAIT);
      check("third slip gap", slip_at[2] - slip_at[1], SEARCH_WORDS + SLIP_WAIT);
    end

    cyc(1'b1, 1'b0, 10'd0);
    @(posedge clk); #2;
    check("scoreboard drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
